mcs4_phase_decoder: RTL and testbench
=====================================

MCS4_PHASE_DECODER -- requirements
Module: mcs4_phase_decoder

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the main design clock; all logic runs on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port PHI1_i, input, 1 bit: MCS-4 phase-1 clock, active-low, synchronous to clk_i.
REQ-004 SHALL have port PHI2_i, input, 1 bit: MCS-4 phase-2 clock, active-low, synchronous to clk_i.
REQ-005 SHALL have port SYNC_i, input, 1 bit: MCS-4 SYNC, active-low, driven during subcycle X3.
REQ-006 SHALL have port subcycle_o, output, 3 bits: current subcycle, 0=A1 through 7=X3.
REQ-007 SHALL have port locked_o, output, 1 bit: decoder is aligned to SYNC.
REQ-008 SHALL have port cycle_start_o, output, 1 bit: one-clk pulse on entry to A1.
REQ-009 SHALL have ports phi1_fall_o, phi1_rise_o, phi2_fall_o and phi2_rise_o, outputs, 1 bit each: one-clk edge pulses.
REQ-010 SHALL have port sync_err_o, output, 1 bit: one-clk pulse on a SYNC protocol violation.
REQ-011 SHALL have port clk_err_o, output, 1 bit: one-clk pulse per clk in which both phases are sampled low.

Function
REQ-012 SHALL sample PHI1_i and PHI2_i into one register stage (p1_q, p2_q) each clk, and keep a second history stage (p1_qq, p2_qq).
REQ-013 SHALL register all outputs; no combinational path from any input to any output.
REQ-014 SHALL assert phiN_fall_o for one clk at edge N+1 when edge N is the first to sample PHIN_i=0 after a 1 (p_qq=1, p_q=0); phiN_rise_o is symmetric.
REQ-015 SHALL assert clk_err_o at edge N+1 when p1_q=0 and p2_q=0 after edge N.
REQ-016 SHALL set an internal sync_seen flag on any clk where p2_q=0 and SYNC_i=0, and clear it at subcycle advance.
REQ-017 SHALL advance the subcycle only on a detected PHI2 rise; subcycle_o changes on the same edge that phi2_rise_o asserts.
REQ-018 SHALL, at advance with sync_seen=1, load subcycle_o=0, set locked_o=1 and pulse cycle_start_o.
REQ-019 SHALL, at advance with sync_seen=1 while locked_o=1 and subcycle_o!=7, additionally pulse sync_err_o; this is a resync and locked_o stays 1.
REQ-020 SHALL, at advance with sync_seen=0, set subcycle_o=(subcycle_o+1) mod 8, and pulse cycle_start_o on the 7->0 wrap.
REQ-021 SHALL, at a 7->0 wrap with sync_seen=0 while locked_o=1, pulse sync_err_o and clear locked_o.
REQ-022 SHALL never assert sync_err_o while locked_o=0.
REQ-023 SHALL keep subcycle_o constant when PHI2 does not toggle, with no timeout.
REQ-024 SHALL treat SYNC_i as ignored while p2_q=1.
REQ-025 SHALL keep edge detection and clk_err_o independent of locked_o.

Reset
REQ-026 SHALL, on rst_i=1 at a clk edge, set subcycle_o=0, locked_o=0, sync_seen=0, all pulse outputs to 0, and p1_q, p1_qq, p2_q and p2_qq to 1.
REQ-027 SHALL give rst_i priority over every other event in the same clk, including mid-subcycle and mid-pulse.
REQ-028 SHALL, if PHIN_i is low when rst_i deasserts, produce a phiN_fall_o pulse 2 clks later.

Verification
Stimulus pattern P: 7-clk period; PHI1_i low at counts 0-1, PHI2_i low at counts 4-5, otherwise high.

REQ-029 SHALL be verified by: reset, then P -> phi1_fall_o at count 1, phi1_rise_o at count 3, phi2_fall_o at count 5, phi2_rise_o at count 0 of the next period (2-clk latency); clk_err_o=0; subcycle_o increments once per period.
REQ-030 SHALL be verified by: P with SYNC_i=0 during PHI2-low of period k -> at the phi2_rise_o edge subcycle_o=0, cycle_start_o=1, locked_o=1; then SYNC_i every 8th period for 3 cycles -> subcycle_o sequence 0..7 repeating, sync_err_o never 1.
REQ-031 SHALL be verified by: from lock, omit SYNC_i in one X3 -> sync_err_o=1 for 1 clk and locked_o=0 at the X3->A1 advance, subcycle_o=0; SYNC_i restored in the next X3 -> locked_o=1 with no sync_err_o.
REQ-032 SHALL be verified by: from lock, assert SYNC_i during subcycle 4 -> at the advance subcycle_o=0, sync_err_o=1 for 1 clk, cycle_start_o=1, locked_o stays 1.
REQ-033 SHALL be verified by: drive PHI1_i=PHI2_i=0 for 1 clk -> clk_err_o=1 for exactly 1 clk, 2 clks later; subcycle_o unaffected.
REQ-034 SHALL be verified by: rst_i=1 for 1 clk while locked at subcycle 5 with PHI1_i low -> next edge all outputs at reset values; phi1_fall_o pulses 2 clks after rst_i deasserts.

Source files
------------

// File: rtl/mcs4_phase_decoder.sv
// Recovers the MCS-4 subcycle (A1..X3) from the two-phase bus clocks and SYNC,
// with registered edge pulses, lock tracking and protocol/clock error pulses.
module mcs4_phase_decoder (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       PHI1_i,
  input  logic       PHI2_i,
  input  logic       SYNC_i,
  output logic [2:0] subcycle_o,
  output logic       locked_o,
  output logic       cycle_start_o,
  output logic       phi1_fall_o,
  output logic       phi1_rise_o,
  output logic       phi2_fall_o,
  output logic       phi2_rise_o,
  output logic       sync_err_o,
  output logic       clk_err_o
);

  typedef enum logic [2:0] {
    SC_A1 = 3'd0, SC_A2 = 3'd1, SC_A3 = 3'd2, SC_M1 = 3'd3,
    SC_M2 = 3'd4, SC_X1 = 3'd5, SC_X2 = 3'd6, SC_X3 = 3'd7
  } subcycle_e;

  logic      p1_q, p1_d, p1_qq, p1_qq_d;
  logic      p2_q, p2_d, p2_qq, p2_qq_d;
  logic      sync_seen_q, sync_seen_d;
  subcycle_e subcycle_q, subcycle_d;
  logic      locked_q, locked_d;
  logic      cycle_start_q, cycle_start_d;
  logic      phi1_fall_q, phi1_fall_d;
  logic      phi1_rise_q, phi1_rise_d;
  logic      phi2_fall_q, phi2_fall_d;
  logic      phi2_rise_q, phi2_rise_d;
  logic      sync_err_q, sync_err_d;
  logic      clk_err_q, clk_err_d;
  logic      advance;

  always_comb begin
    p1_d    = PHI1_i;
    p2_d    = PHI2_i;
    p1_qq_d = p1_q;
    p2_qq_d = p2_q;

    phi1_fall_d = p1_qq & ~p1_q;
    phi1_rise_d = ~p1_qq & p1_q;
    phi2_fall_d = p2_qq & ~p2_q;
    phi2_rise_d = ~p2_qq & p2_q;
    clk_err_d   = ~p1_q & ~p2_q;

    // The subcycle steps on the same edge that reports the PHI2 rise.
    advance = ~p2_qq & p2_q;

    // SYNC only counts while PHI2 is (registered) low.
    sync_seen_d   = sync_seen_q | (~p2_q & ~SYNC_i);
    subcycle_d    = subcycle_q;
    locked_d      = locked_q;
    cycle_start_d = 1'b0;
    sync_err_d    = 1'b0;

    if (advance) begin
      sync_seen_d = 1'b0;
      if (sync_seen_q) begin
        subcycle_d    = SC_A1;
        locked_d      = 1'b1;
        cycle_start_d = 1'b1;
        sync_err_d    = locked_q & (subcycle_q != SC_X3);
      end else begin
        subcycle_d = subcycle_e'(subcycle_q + 3'd1);
        if (subcycle_q == SC_X3) begin
          cycle_start_d = 1'b1;
          // A wrap without SYNC while locked means we lost alignment.
          if (locked_q) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_q          <= 1'b1;
      p1_qq         <= 1'b1;
      p2_q          <= 1'b1;
      p2_qq         <= 1'b1;
      sync_seen_q   <= 1'b0;
      subcycle_q    <= SC_A1;
      locked_q      <= 1'b0;
      cycle_start_q <= 1'b0;
      phi1_fall_q   <= 1'b0;
      phi1_rise_q   <= 1'b0;
      phi2_fall_q   <= 1'b0;
      phi2_rise_q   <= 1'b0;
      sync_err_q    <= 1'b0;
      clk_err_q     <= 1'b0;
    end else begin
      p1_q          <= p1_d;
      p1_qq         <= p1_qq_d;
      p2_q          <= p2_d;
      p2_qq         <= p2_qq_d;
      sync_seen_q   <= sync_seen_d;
      subcycle_q    <= subcycle_d;
      locked_q      <= locked_d;
      cycle_start_q <= cycle_start_d;
      phi1_fall_q   <= phi1_fall_d;
      phi1_rise_q   <= phi1_rise_d;
      phi2_fall_q   <= phi2_fall_d;
      phi2_rise_q   <= phi2_rise_d;
      sync_err_q    <= sync_err_d;
      clk_err_q     <= clk_err_d;
    end
  end

  assign subcycle_o    = subcycle_q;
  assign locked_o      = locked_q;
  assign cycle_start_o = cycle_start_q;
  assign phi1_fall_o   = phi1_fall_q;
  assign phi1_rise_o   = phi1_rise_q;
  assign phi2_fall_o   = phi2_fall_q;
  assign phi2_rise_o   = phi2_rise_q;
  assign sync_err_o    = sync_err_q;
  assign clk_err_o     = clk_err_q;

endmodule

// File: tb/tb_mcs4_phase_decoder.sv
// Directed bench for mcs4_phase_decoder: each expected pulse event is queued with
// the clk edge it must appear on; a negedge monitor pops and compares.
module tb_mcs4_phase_decoder;

  localparam int W = 27;
  localparam logic [6:0] F1 = 7'b1000000;
  localparam logic [6:0] R1 = 7'b0100000;
  localparam logic [6:0] F2 = 7'b0010000;
  localparam logic [6:0] R2 = 7'b0001000;
  localparam logic [6:0] CS = 7'b0000100;
  localparam logic [6:0] SE = 7'b0000010;
  localparam logic [6:0] CE = 7'b0000001;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic phi1 = 1'b1;
  logic phi2 = 1'b1;
  logic sync_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] subcycle;
  logic locked, cycle_start, phi1_fall, phi1_rise, phi2_fall, phi2_rise, sync_err, clk_err;

  mcs4_phase_decoder dut (
    .clk_i(clk), .rst_i(rst), .PHI1_i(phi1), .PHI2_i(phi2), .SYNC_i(sync_n),
    .subcycle_o(subcycle), .locked_o(locked), .cycle_start_o(cycle_start),
    .phi1_fall_o(phi1_fall), .phi1_rise_o(phi1_rise),
    .phi2_fall_o(phi2_fall), .phi2_rise_o(phi2_rise),
    .sync_err_o(sync_err), .clk_err_o(clk_err)
  );

  logic [10:0] obs;
  assign obs = {phi1_fall, phi1_rise, phi2_fall, phi2_rise, cycle_start, sync_err, clk_err,
                locked, subcycle};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [2:0] es = 3'd0;
  logic el = 1'b0;

  function automatic logic [W-1:0] mk(input int stamp, input logic [6:0] pulses,
                                      input logic lk, input logic [2:0] sub);
    logic [31:0] s;
    s = stamp;
    return {s[15:0], pulses, lk, sub};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] got, e;
    logic [31:0] c;
    c = cyc;
    got = {c[15:0], obs};
    if (|obs[10:4]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%h (stamp,pulses,lk,sub) required none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pulse_event got=%h required=%h", got, e);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic a, input logic b, input logic s);
    phi1 = a;
    phi2 = b;
    sync_n = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [2:0] sub, input logic lk);
    checks++;
    if ({subcycle, locked, obs[10:4]} !== {sub, lk, 7'b0}) begin
      errors++;
      $display("FAIL %s got sub=%0d lk=%0b pulses=%b required sub=%0d lk=%0b pulses=0000000",
               name, subcycle, locked, obs[10:4], sub, lk);
    end
  endtask

  // One 7-clk period of pattern P; dual adds a 1-clk PHI1 low overlapping PHI2 low.
  task automatic period(input logic with_sync, input logic dual, input logic tail,
                        input logic [2:0] nsub, input logic nlk,
                        input logic ncs, input logic nse);
    int e0;
    e0 = cyc + 1;
    exp_q.push_back(mk(e0 + 1, F1, el, es));
    exp_q.push_back(mk(e0 + 3, R1, el, es));
    if (dual) begin
      exp_q.push_back(mk(e0 + 5, F2 | F1 | CE, el, es));
      exp_q.push_back(mk(e0 + 6, R1, el, es));
    end else begin
      exp_q.push_back(mk(e0 + 5, F2, el, es));
    end
    if (tail)
      exp_q.push_back(mk(e0 + 7, R2 | (ncs ? CS : 7'd0) | (nse ? SE : 7'd0), nlk, nsub));
    for (int c = 0; c < 7; c++)
      drive(!(c <= 1 || (dual && c == 4)), !(c == 4 || c == 5),
            !(with_sync && (c == 4 || c == 5)));
    if (tail) begin
      es = nsub;
      el = nlk;
    end
  endtask

  initial begin
    int r;
    repeat (3) drive(1, 1, 1);
    check_state("reset_values", 3'd0, 1'b0);
    rst = 1'b0;
    repeat (3) drive(1, 1, 1);
    check_state("idle_after_reset", 3'd0, 1'b0);

    // free-running, unlocked
    period(0, 0, 1, 3'd1, 0, 0, 0);
    period(0, 0, 1, 3'd2, 0, 0, 0);
    period(0, 0, 1, 3'd3, 0, 0, 0);
    repeat (10) drive(1, 1, 1);
    check_state("hold_without_phi2", 3'd3, 1'b0);

    // first SYNC locks
    period(1, 0, 1, 3'd0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i < 8; i++) period(0, 0, 1, 3'(i), 1, 0, 0);
      period(1, 0, 1, 3'd0, 1, 1, 0);
    end

    // missing SYNC in X3: lose lock, then relock
    for (int i = 1; i < 8; i++) period(0, 0, 1, 3'(i), 1, 0, 0);
    period(0, 0, 1, 3'd0, 0, 1, 1);
    for (int i = 1; i < 8; i++) period(0, 0, 1, 3'(i), 0, 0, 0);
    period(1, 0, 1, 3'd0, 1, 1, 0);

    // early SYNC in subcycle 4: resync with error, lock kept
    for (int i = 1; i < 5; i++) period(0, 0, 1, 3'(i), 1, 0, 0);
    period(1, 0, 1, 3'd0, 1, 1, 1);

    // both phases low for one clk
    period(0, 1, 1, 3'd1, 1, 0, 0);

    // reach subcycle 5 locked, then reset on the advance edge with PHI1 low
    for (int i = 2; i < 6; i++) period(0, 0, 1, 3'(i), 1, 0, 0);
    period(0, 0, 0, 3'd6, 1, 0, 0);
    rst = 1'b1;
    drive(0, 1, 1);
    check_state("reset_mid_pulse", 3'd0, 1'b0);
    r = cyc;
    es = 3'd0;
    el = 1'b0;
    exp_q.push_back(mk(r + 2, F1, 1'b0, 3'd0));
    exp_q.push_back(mk(r + 4, R1, 1'b0, 3'd0));
    rst = 1'b0;
    drive(0, 1, 1);
    drive(0, 1, 1);
    drive(1, 1, 1);
    repeat (6) drive(1, 1, 1);
    check_state("after_reset_idle", 3'd0, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d left in queue required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
